// File: rtl/dmem_pkg.sv
// Shared types and encodings for the data-side memory bridge.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  // Size 3 is reserved and behaves like a word access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      default:   return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane alignment: shifts store strobes to the byte offset and
// replicates store data across lanes according to access size.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [3:0]  wen_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o
);

  // Lanes shifted past bit 3 fall off; misaligned stores keep only what fits.
  assign wstrb_o = wen_i << off_i;

  always_comb begin
    wdata_o = wdata_i;
    case (size_i)
      SIZE_BYTE: wdata_o = {4{wdata_i[7:0]}};
      SIZE_HALF: wdata_o = {2{wdata_i[15:0]}};
      default:   wdata_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// M-stage data memory bridge: one bus access per instruction, stall while in flight.
// Optional misalignment trap enabled by defining DMEM_ADDR_CHECK_EN.
module dmem_bridge
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        pipe_stall,
  output logic [31:0] mem_rdata,
  output logic        stall_req,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        addr_err
);

  state_e      state_q, state_d;
  logic        flush_q, flush_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic        misal;
  logic        start;
  logic        kill;

  dmem_lane_align u_align (
    .wen_i   (mem_wen),
    .size_i  (mem_size),
    .off_i   (mem_addr[1:0]),
    .wdata_i (mem_wdata),
    .wstrb_o (al_wstrb),
    .wdata_o (al_wdata)
  );

`ifdef DMEM_ADDR_CHECK_EN
  assign misal = misaligned(mem_size, mem_addr[1:0]);
`else
  assign misal = 1'b0;
`endif

  assign start    = (state_q == S_IDLE) && mem_en && !misal;
  assign addr_err = (state_q == S_IDLE) && mem_en && misal;
  // A dropped mem_en means the instruction was flushed; the bus beat still completes.
  assign kill     = flush_q || !mem_en;

  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    rdata_d   = rdata_q;
    stall_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_req = start;
        if (start) begin
          state_d = S_ADDR;
          flush_d = 1'b0;
        end
      end
      S_ADDR: begin
        stall_req = 1'b1;
        if (!mem_en)      flush_d = 1'b1;
        if (data_addr_ok) state_d = S_DATA;
      end
      S_DATA: begin
        stall_req = 1'b1;
        if (!mem_en) flush_d = 1'b1;
        if (data_data_ok) begin
          state_d = S_DONE;
          if (!wr_q && !kill) rdata_d = data_rdata;
        end
      end
      S_DONE: begin
        if (flush_q || !pipe_stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      flush_q <= 1'b0;
      rdata_q <= '0;
      size_q  <= '0;
      addr_q  <= '0;
      wstrb_q <= STRB_NONE;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      rdata_q <= rdata_d;
      if (start) begin
        size_q  <= mem_size;
        addr_q  <= mem_addr;
        wstrb_q <= al_wstrb;
        wdata_q <= al_wdata;
        wr_q    <= |mem_wen;
      end
    end
  end

  assign data_req   = (state_q == S_ADDR);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wstrb = wstrb_q;
  assign data_wdata = wdata_q;
  assign mem_rdata  = rdata_q;

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-side memory bridge between the M stage of the pipelined MIPS core and the SRAM-like data bus. It takes one access per instruction (address, strobes, store data), aligns strobes and store data to the byte lane, runs the request/address/data handshake, and returns the raw read word to the M/W boundary. While an access is in flight it raises a stall request into the hazard unit.

## Interface
- No parameters; widths fixed at 32-bit address/data.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_en  in  1  M-stage instruction performs a load or store this cycle
- mem_wen  in  4  store strobes, low-lane aligned: 0001 byte, 0011 half, 1111 word; 0000 = load
- mem_size  in  2  0 byte, 1 half, 2 word; 3 reserved, treated as word
- mem_addr  in  32  full byte address (unmasked ALU result)
- mem_wdata  in  32  store data, value in low bits
- pipe_stall  in  1  M stage held by another stall source
- mem_rdata  out  32  raw word read (lane extraction done downstream)
- stall_req  out  1  hold F..M until access completes
- data_req / data_wr  out  1 / 1  bus request valid / write
- data_size  out  2  latched mem_size
- data_addr  out  32  latched mem_addr
- data_wstrb  out  4  lane-shifted strobes
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted this cycle
- data_data_ok  in  1  read data valid / write committed this cycle
- data_rdata  in  32  bus read data
- addr_err  out  1  misaligned access (macro only; else tied 0)

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: if mem_en, latch request fields, go ADDR. Else stay.
- ADDR: data_req=1, fields stable; on data_addr_ok go DATA. data_data_ok in ADDR ignored (bus never returns data in the accept cycle).
- DATA: data_req=0; on data_data_ok capture data_rdata into mem_rdata (loads only; stores leave it), go DONE.
- DONE: if pipe_stall stay (mem_rdata held); else go IDLE.
- stall_req = (IDLE & mem_en) | ADDR | DATA. Deasserted in DONE so the instruction advances.
- Lane align: data_wstrb = (mem_wen << addr[1:0]) truncated to 4 bits; data_wdata = {4{wdata[7:0]}} byte, {2{wdata[15:0]}} half, wdata word; data_wr = |mem_wen.
- Flush mid-access (mem_en drops in ADDR/DATA): bus transaction cannot be cancelled; FSM completes, discards result (mem_rdata unchanged), DONE->IDLE next cycle; stall_req held until DATA exits.
- mem_en high in IDLE entered from DONE starts the next access with no gap.

## Timing
- Reset: state IDLE, data_req 0, data_wr 0, data_size/addr/wstrb/wdata 0, mem_rdata 0, stall_req 0, addr_err 0.
- Best case (addr_ok first ADDR cycle, data_ok next): IDLE c0, ADDR c1, DATA c2, DONE c3; stall_req high c0-c2, mem_rdata valid from c3.
- Each bus wait cycle adds one stall cycle. Bus outputs are registered; stall_req is combinational from state and mem_en.
- Async reset mid-access returns to IDLE immediately; bus side must tolerate abandoned transaction.

## Configuration
- DMEM_ADDR_CHECK_EN defined: in IDLE, half with addr[0]=1 or word with addr[1:0]!=0 produces addr_err=1 for that cycle, no transition, stall_req=0, no bus request.
- Undefined: addr_err tied 0; misaligned accesses issued unchanged with truncated strobes.

## Structure
- Package dmem_pkg: state enum, size encodings (SIZE_BYTE/HALF/WORD), strobe constants.
- One sub-module dmem_lane_align: combinational strobe shift and data replication.

## Test plan
- Load word addr 0x1000, addr_ok c1, data_ok c2 rdata 0xDEADBEEF -> stall 3 cycles, mem_rdata=0xDEADBEEF at c3, data_wr=0.
- Store byte addr 0x1003, wdata 0x000000A5 -> data_wstrb=1000, data_wdata=0xA5A5A5A5, data_wr=1.
- Store half addr 0x2002 with addr_ok delayed 4 cycles -> data_req held with stable fields, stall 7 cycles, wstrb=1100.
- pipe_stall high 2 cycles in DONE -> state DONE held, mem_rdata unchanged, stall_req=0.
- mem_en drops in DATA (flush) -> data_ok still consumed, mem_rdata keeps prior value, IDLE after DONE.
- With DMEM_ADDR_CHECK_EN, load word addr 0x1002 -> addr_err=1 one cycle, data_req never asserted.
